// File: rtl/price_display_if.sv
// Price handshake and converted-BCD result bundle between the price calculator and the display block.
interface price_display_if #(
  parameter int W      = 16,
  parameter int DIGITS = 5
);
  logic [W-1:0]        price_in;
  logic                price_valid;
  logic                price_ready;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;

  modport master (output price_in, price_valid, input price_ready, bcd, bcd_valid);
  modport slave  (input price_in, price_valid, output price_ready, bcd, bcd_valid);
endinterface

// File: rtl/price_display.sv
// Accepts a binary price, converts it to packed BCD with a sequential double-dabble
// engine, and scans the result onto a multiplexed active-low 7-segment display.
module price_display #(
  parameter int W           = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000,
  parameter int LZB         = 1
) (
  input  logic              clk,
  input  logic              rst,
  price_display_if.slave    bus,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int CNT_W = $clog2(W + 1);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW    = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_next;
  logic             ready_q;
  logic             valid_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    scratch;
  logic [BW-1:0]    adj;
  logic [W-1:0]     bin;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic [REF_W-1:0]  ref_cnt;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        cur_nib;
  logic              upper_nz;
  logic [6:0]        seg_next;
  logic [DIGITS-1:0] an_next;

  assign accept          = bus.price_valid && ready_q;
  assign bus.price_ready = ready_q;
  assign bus.bcd         = bcd_q;
  assign bus.bcd_valid   = valid_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CONV;
      CONV:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction applied to every nibble before the shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      scratch <= '0;
      bin     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      ready_q <= (state_next == IDLE);
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bin     <= bus.price_in;
            scratch <= '0;
            cnt     <= CNT_W'(W);
          end
        end
        CONV: begin
          scratch <= {adj[BW-2:0], bin[W-1]};
          bin     <= {bin[W-2:0], 1'b0};
          cnt     <= cnt - 1'b1;
        end
        DONE: begin
          bcd_q   <= scratch;
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Digit selection and leading-zero blanking work only on the committed bcd_q, so the display never tears.
  always_comb begin
    cur_nib  = 4'd0;
    upper_nz = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_nib = bcd_q[4*i +: 4];
      if ((IDX_W'(i) >= idx) && (bcd_q[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
    end
    case (cur_nib)
      4'd0:    seg_next = 7'h40;
      4'd1:    seg_next = 7'h79;
      4'd2:    seg_next = 7'h24;
      4'd3:    seg_next = 7'h30;
      4'd4:    seg_next = 7'h19;
      4'd5:    seg_next = 7'h12;
      4'd6:    seg_next = 7'h02;
      4'd7:    seg_next = 7'h78;
      4'd8:    seg_next = 7'h00;
      4'd9:    seg_next = 7'h10;
      default: seg_next = 7'h7F;
    endcase
    if ((LZB != 0) && (idx != '0) && !upper_nz) seg_next = 7'h7F;
    an_next = ~(DIGITS'(1) << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      seg     <= 7'h7F;
      an      <= '1;
    end else begin
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: tb/tb_price_display.sv
// Self-checking bench for price_display: a decimal-arithmetic reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_price_display;
  localparam int W           = 16;
  localparam int DIGITS      = 5;
  localparam int REFRESH_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [4:0] an;
  int total = 0;
  int bad   = 0;

  price_display_if #(.W(W), .DIGITS(DIGITS)) bus();

  price_display #(.W(W), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV), .LZB(1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input int v, input int i);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (i != 0 && v < p) return 7'h7F;
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a price is committed 17 edges after acceptance, digits come from decimal division.
  int         m_value, m_pending, m_busy, m_phase, m_idx;
  bit         m_ready, m_valid, armed = 1'b0;
  logic [6:0] m_seg;
  logic [4:0] m_an;

  always @(posedge clk) begin
    if (rst) begin
      m_value = 0; m_busy = 0; m_ready = 1'b0; m_valid = 1'b0;
      m_seg = 7'h7F; m_an = 5'h1F; m_phase = 0; armed = 1'b1;
    end else begin
      m_idx   = (m_phase / REFRESH_DIV) % DIGITS;
      m_an    = ~(5'b1 << m_idx);
      m_seg   = digit_seg(m_value, m_idx);
      m_phase = m_phase + 1;
      m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_value = m_pending; m_valid = 1'b1; m_ready = 1'b1;
        end
      end else if (m_ready && bus.price_valid) begin
        m_pending = int'(bus.price_in); m_busy = W + 1; m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("model_bcd", bus.bcd, to_bcd(m_value));
      checkOutput("model_bcd_valid", bus.bcd_valid, m_valid);
      checkOutput("model_ready", bus.price_ready, m_ready);
      checkOutput("model_seg", seg, m_seg);
      checkOutput("model_an", an, m_an);
    end
  end

  // Waits (bounded) for ready, presents the price for the accept edge, optionally keeps valid high with a new price.
  task automatic applyStimulus(input logic [15:0] p, input int hold_extra, input logic [15:0] p_after);
    int waited;
    waited = 0;
    while (!bus.price_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_wait_timeout", (waited < 50), 1);
    bus.price_in    = p;
    bus.price_valid = 1'b1;
    @(negedge clk);
    if (hold_extra > 0) begin
      bus.price_in = p_after;
      repeat (hold_extra) @(negedge clk);
    end
    bus.price_valid = 1'b0;
  endtask

  task automatic wait_result(output int cycles);
    cycles = 0;
    while (!bus.bcd_valid && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  logic [4:0] exp_an  [5] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F};
  logic [6:0] exp_seg [5] = '{7'h40, 7'h40, 7'h40, 7'h24, 7'h79};

  initial begin
    int cyc, seen, found;
    logic [4:0] prev;
    rst = 1'b1;
    bus.price_in = '0;
    bus.price_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_seg", seg, 7'h7F);
    checkOutput("rst_an", an, 5'h1F);
    checkOutput("rst_ready", bus.price_ready, 0);
    checkOutput("rst_bcd", bus.bcd, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", bus.price_ready, 1);

    $display("[TB] accept 12000");
    applyStimulus(16'd12000, 0, 16'd0);
    wait_result(cyc);
    checkOutput("latency_12000", cyc, 17);
    checkOutput("bcd_12000", bus.bcd, 20'h12000);

    $display("[TB] back-to-back 65535 then 0");
    applyStimulus(16'd65535, 0, 16'd0);
    wait_result(cyc);
    checkOutput("bcd_65535", bus.bcd, 20'h65535);
    checkOutput("ready_at_17", bus.price_ready, 1);
    applyStimulus(16'd0, 0, 16'd0);
    wait_result(cyc);
    checkOutput("latency_b2b", cyc, 17);
    checkOutput("bcd_zero", bus.bcd, 20'h00000);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (an == 5'h1E) checkOutput("zero_digit0_seg", seg, 7'h40);
      else             checkOutput("zero_blank_seg", seg, 7'h7F);
      @(negedge clk);
    end

    $display("[TB] valid held during conversion");
    applyStimulus(16'd4321, 10, 16'd9999);
    wait_result(cyc);
    checkOutput("latency_held", cyc, 7);
    checkOutput("bcd_4321", bus.bcd, 20'h04321);
    @(negedge clk);

    $display("[TB] reset mid-conversion");
    applyStimulus(16'd5555, 0, 16'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_bcd", bus.bcd, 0);
    checkOutput("abort_ready_in_rst", bus.price_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready_after", bus.price_ready, 1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.bcd_valid) seen++;
    end
    checkOutput("abort_no_valid", seen, 0);
    checkOutput("abort_bcd_kept", bus.bcd, 0);

    $display("[TB] refresh scan of 12000");
    applyStimulus(16'd12000, 0, 16'd0);
    wait_result(cyc);
    checkOutput("bcd_12000_again", bus.bcd, 20'h12000);
    found = 0;
    prev = an;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (an == 5'h1E && prev != 5'h1E) found = 1;
      prev = an;
    end
    checkOutput("scan_start_found", found, 1);
    if (found != 0) begin
      for (int k = 0; k < 24; k++) begin
        checkOutput("scan_an", an, exp_an[(k / 4) % 5]);
        checkOutput("scan_seg", seg, exp_seg[(k / 4) % 5]);
        @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
